// File: rtl/sr_latch_driver.sv
// sr_latch_driver
// Synchronous front-end for a downstream asynchronous S-R latch. Raw set/reset
// request levels are synchronised, debounced and edge-detected into one-deep
// pending flags. A small FSM then drives exactly one fixed-width S or R pulse,
// waits a settle cycle and checks the latch's Q/Qbar feedback. S and R are
// decoded from a single state register, so they can never both be high.
//
// Handshake: there is no valid/ready pair on this block. Requests are level
// inputs that are never back-pressured; a request that arrives while busy is
// held in its pending flag, and duplicates of a still-pending request merge.

module sr_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 4,  // stable samples to move a filtered level, >= 1
    parameter int PULSE_CYCLES    = 2   // cycles S or R is held per drive, >= 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic       reset_req,
    input  logic       Q,
    input  logic       Qbar,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       state_exp,
    output logic       fault,
    output logic [2:0] dbg_state
);

    // Counter widths; a width of at least one bit keeps the value-1 cases legal.
    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    // Terminal counts: the flip / pulse end happens when the counter already
    // holds N-1, so the event lands on the N-th qualifying edge.
    localparam logic [DCW-1:0] D_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCW-1:0] P_LAST = PCW'(PULSE_CYCLES - 1);

    // Channel index used by the per-request arrays below.
    localparam int CH_SET = 0;
    localparam int CH_RST = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE_S = 3'd1,
        ST_DRIVE_R = 3'd2,
        ST_GAP     = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Request front-end state
    // ------------------------------------------------------------------
    logic [1:0]     req_raw;
    logic [1:0]     sync1_q, sync1_d;
    logic [1:0]     sync2_q, sync2_d;
    logic [1:0]     filt_q, filt_d;
    logic [DCW-1:0] dcnt_q [2];
    logic [DCW-1:0] dcnt_d [2];
    logic           set_rise;
    logic           rst_rise;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           pend_set_q, pend_set_d;
    logic           pend_rst_q, pend_rst_d;
    logic           state_exp_q, state_exp_d;
    logic           fault_q, fault_d;
    logic           s_q, s_d;
    logic           r_q, r_d;
    logic           busy_q, busy_d;

    assign req_raw = {reset_req, set_req};

    // Two-flop synchroniser chain for both raw request lines.
    always_comb begin
        sync1_d = req_raw;
        sync2_d = sync1_q;
    end

    // Debounce: count consecutive samples that disagree with the filtered
    // level; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (dcnt_q[i] == D_LAST) begin
                    filt_d[i] = sync2_q[i];
                    dcnt_d[i] = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Rising edges of the filtered levels are taken from the next-value side
    // so the pending flag is written on the same edge the level flips.
    always_comb begin
        set_rise = filt_d[CH_SET] & ~filt_q[CH_SET];
        rst_rise = filt_d[CH_RST] & ~filt_q[CH_RST];
    end

    // Sequencer next-state, pending-flag bookkeeping and check logic.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        pend_set_d  = pend_set_q;
        pend_rst_d  = pend_rst_q;
        state_exp_d = state_exp_q;
        fault_d     = fault_q;

        case (state_q)
            ST_IDLE: begin
                // Reset wins over set when both are waiting.
                if (pend_rst_q) begin
                    state_d     = ST_DRIVE_R;
                    pend_rst_d  = 1'b0;
                    pcnt_d      = '0;
                    state_exp_d = 1'b0;
                end else if (pend_set_q) begin
                    state_d     = ST_DRIVE_S;
                    pend_set_d  = 1'b0;
                    pcnt_d      = '0;
                    state_exp_d = 1'b1;
                end
            end
            ST_DRIVE_S, ST_DRIVE_R: begin
                if (pcnt_q == P_LAST) begin
                    state_d = ST_GAP;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                // Both drives low for one cycle so the latch can settle.
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Q==Qbar fails one of the two comparisons, so it is caught too.
                if ((Q != state_exp_q) || (Qbar != ~state_exp_q)) begin
                    fault_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New requests are merged after the IDLE hand-off so an edge arriving
        // on the same cycle a flag is consumed re-arms it. A simultaneous set
        // edge is dropped in favour of reset.
        if (rst_rise) begin
            pend_rst_d = 1'b1;
        end else if (set_rise) begin
            pend_set_d = 1'b1;
        end
    end

    // Registered latch drives and status, decoded from the next state so
    // they change on the same edge as the state register.
    always_comb begin
        s_d    = (state_d == ST_DRIVE_S);
        r_d    = (state_d == ST_DRIVE_R);
        busy_d = (state_d != ST_IDLE);
    end

    // Synchroniser and debounce registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    // Sequencer state, pending flags and sticky fault.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pcnt_q      <= '0;
            pend_set_q  <= 1'b0;
            pend_rst_q  <= 1'b0;
            state_exp_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            pend_set_q  <= pend_set_d;
            pend_rst_q  <= pend_rst_d;
            state_exp_q <= state_exp_d;
            fault_q     <= fault_d;
        end
    end

    // Output registers; reset forces both latch drives low on the reset edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            r_q    <= r_d;
            busy_q <= busy_d;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign busy      = busy_q;
    assign state_exp = state_exp_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule
